// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input vector of a small combinational gate and checks
// its output against a truth table, reporting pass/fail and the first bad vector.
module gate_sweep_ctrl #(
   parameter int unsigned         N_IN   = 2,
   parameter logic [2**N_IN-1:0]  TRUTH  = 4'b0110,
   parameter int unsigned         SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            gate_y,
   output logic [N_IN-1:0] vec_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [N_IN-1:0] VEC_LAST = '1;
   localparam logic [3:0] CNT_LAST =
      (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
   // With no settle time every vector goes straight to CHECK
   localparam logic [1:0] S_NEXT_VEC =
      (SETTLE == 0) ? S_CHECK : S_SETTLE;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          mismatch;
   logic [N_IN:0] err_next;

   assign mismatch = (gate_y != TRUTH[vec_out]);

   always_comb begin
      err_next = err_count;
      if (mismatch)
         err_next = err_count + {{N_IN{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         cnt            <= 4'd0;
         vec_out        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         fail_valid     <= 1'b0;
         first_fail_vec <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               vec_out <= '0;
               busy    <= 1'b0;
               if (start && !abort) begin
                  state          <= S_NEXT_VEC;
                  busy           <= 1'b1;
                  cnt            <= 4'd0;
                  pass           <= 1'b0;
                  err_count      <= '0;
                  fail_valid     <= 1'b0;
                  first_fail_vec <= '0;
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  state   <= S_IDLE;
                  vec_out <= '0;
                  busy    <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state <= S_CHECK;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            S_CHECK: begin
               // Scoring happens even when abort arrives this cycle
               if (mismatch) begin
                  err_count <= err_next;
                  if (!fail_valid) begin
                     fail_valid     <= 1'b1;
                     first_fail_vec <= vec_out;
                  end
               end
               if (abort) begin
                  state   <= S_IDLE;
                  vec_out <= '0;
                  busy    <= 1'b0;
               end else if (vec_out == VEC_LAST) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state   <= S_NEXT_VEC;
                  vec_out <= vec_out + 1'b1;
                  cnt     <= 4'd0;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               vec_out <= '0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two configurations, directed and random
// sweeps checked against a truth-table scoring model.
module tb_gate_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst, abort;
   logic       start_a, start_b;
   logic [3:0] gt_a;
   logic [7:0] gt_b;
   logic       gy_a, gy_b;

   logic [1:0] vec_a, ffv_a;
   logic [2:0] err_a;
   logic       busy_a, done_a, pass_a, fv_a;
   logic [2:0] vec_b, ffv_b;
   logic [3:0] err_b;
   logic       busy_b, done_b, pass_b, fv_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign gy_a = gt_a[vec_a];
   assign gy_b = gt_b[vec_b];

   gate_sweep_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort),
      .gate_y(gy_a), .vec_out(vec_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .err_count(err_a), .fail_valid(fv_a),
      .first_fail_vec(ffv_a)
   );

   gate_sweep_ctrl #(.N_IN(3), .TRUTH(8'h96), .SETTLE(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort),
      .gate_y(gy_b), .vec_out(vec_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_count(err_b), .fail_valid(fv_b),
      .first_fail_vec(ffv_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic grab(input int d, output logic [31:0] v,
                       output logic [31:0] b, output logic [31:0] dn,
                       output logic [31:0] p, output logic [31:0] e,
                       output logic [31:0] fv, output logic [31:0] ff);
      v  = d ? 32'(vec_b)  : 32'(vec_a);
      b  = d ? 32'(busy_b) : 32'(busy_a);
      dn = d ? 32'(done_b) : 32'(done_a);
      p  = d ? 32'(pass_b) : 32'(pass_a);
      e  = d ? 32'(err_b)  : 32'(err_a);
      fv = d ? 32'(fv_b)   : 32'(fv_a);
      ff = d ? 32'(ffv_b)  : 32'(ffv_a);
   endtask

   task automatic set_start(input int d, input logic val);
      if (d != 0) start_b = val;
      else start_a = val;
   endtask

   // Mismatches among vectors whose CHECK cycle is at or before cycle k
   task automatic score(input logic [7:0] gt, input logic [7:0] tr,
                        input int n, input int per, input int k,
                        output int err, output int ff);
      err = 0;
      ff  = 0;
      for (int v = 0; v < n; v++) begin
         if ((v + 1) * per <= k && gt[v] != tr[v]) begin
            if (err == 0) ff = v;
            err++;
         end
      end
   endtask

   task automatic chk_reset(input int d, input string nm);
      logic [31:0] v, b, dn, p, e, fv, ff;
      grab(d, v, b, dn, p, e, fv, ff);
      chk({nm, ":vec"}, v, 0);
      chk({nm, ":busy"}, b, 0);
      chk({nm, ":done"}, dn, 0);
      chk({nm, ":pass"}, p, 0);
      chk({nm, ":err"}, e, 0);
      chk({nm, ":fv"}, fv, 0);
      chk({nm, ":ffv"}, ff, 0);
   endtask

   task automatic sweep(input int d, input logic [7:0] gt,
                        input int abort_at, input int restart_at,
                        input string nm);
      logic [31:0] v, b, dn, p, e, fv, ff;
      logic [7:0] tr;
      int n, per, total, dc, xe, xf;
      n     = d ? 8 : 4;
      per   = d ? 1 : 2;
      tr    = d ? 8'h96 : 8'h06;
      total = n * per;
      dc    = total + 1;
      if (d != 0) gt_b = gt;
      else gt_a = gt[3:0];
      set_start(d, 1'b1);
      step();
      set_start(d, 1'b0);
      for (int c = 1; c <= dc; c++) begin
         grab(d, v, b, dn, p, e, fv, ff);
         chk({nm, ":busy"}, b, 1);
         chk({nm, ":done"}, dn, 32'(c == dc));
         if (c <= total) chk({nm, ":vec"}, v, 32'((c - 1) / per));
         if (c == 1) begin
            chk({nm, ":clr_err"}, e, 0);
            chk({nm, ":clr_fv"}, fv, 0);
            chk({nm, ":clr_pass"}, p, 0);
         end
         if (c == abort_at) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            score(gt, tr, n, per, c, xe, xf);
            for (int j = 0; j < 3; j++) begin
               grab(d, v, b, dn, p, e, fv, ff);
               chk({nm, ":ab_busy"}, b, 0);
               chk({nm, ":ab_done"}, dn, 0);
               chk({nm, ":ab_vec"}, v, 0);
               chk({nm, ":ab_pass"}, p, 0);
               chk({nm, ":ab_err"}, e, 32'(xe));
               chk({nm, ":ab_fv"}, fv, 32'(xe != 0));
               chk({nm, ":ab_ffv"}, ff, 32'(xf));
               step();
            end
            return;
         end
         set_start(d, c == restart_at);
         if (c < dc) step();
      end
      set_start(d, 1'b0);
      score(gt, tr, n, per, total, xe, xf);
      chk({nm, ":pass"}, p, 32'(xe == 0));
      chk({nm, ":err"}, e, 32'(xe));
      chk({nm, ":fv"}, fv, 32'(xe != 0));
      chk({nm, ":ffv"}, ff, 32'(xf));
      step();
      grab(d, v, b, dn, p, e, fv, ff);
      chk({nm, ":idle_busy"}, b, 0);
      chk({nm, ":idle_done"}, dn, 0);
      chk({nm, ":idle_vec"}, v, 0);
      chk({nm, ":held_pass"}, p, 32'(xe == 0));
      chk({nm, ":held_err"}, e, 32'(xe));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int d, tot, ab, rs;
      logic [31:0] v, b, dn, p, e, fv, ff;
      rst = 1'b1;
      abort = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      gt_a = 4'b0110;
      gt_b = 8'h96;
      step();
      step();
      rst = 1'b0;
      chk_reset(0, "rst_a");
      chk_reset(1, "rst_b");

      sweep(0, 8'h06, 0, 0, "xor");
      sweep(0, 8'h00, 0, 0, "stuck0");
      sweep(0, 8'h09, 0, 0, "xnor");
      sweep(0, 8'h06, 4, 0, "abort4");
      sweep(0, 8'h06, 0, 0, "restart");
      sweep(0, 8'h00, 0, 3, "ignore_start");
      sweep(1, 8'h96, 0, 0, "xor3");
      sweep(1, 8'h69, 0, 0, "xnor3");

      // start and abort together in IDLE: abort wins
      start_a = 1'b1;
      abort = 1'b1;
      step();
      start_a = 1'b0;
      abort = 1'b0;
      grab(0, v, b, dn, p, e, fv, ff);
      chk("start_abort:busy", b, 0);
      step();
      grab(0, v, b, dn, p, e, fv, ff);
      chk("start_abort:busy2", b, 0);

      // reset mid-sweep, with a mismatch already scored
      gt_a = 4'b0000;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      step();
      step();
      step();
      step();
      grab(0, v, b, dn, p, e, fv, ff);
      chk("pre_rst:err", e, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset(0, "mid_rst");
      step();
      chk_reset(0, "mid_rst_idle");

      for (int i = 0; i < 8; i++) begin
         d   = int'($urandom_range(0, 1));
         tot = d ? 8 : 8;
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tot)) : 0;
         rs  = int'($urandom_range(0, tot));
         sweep(d, 8'($urandom), ab, rs, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
